cla_4b: RTL and testbench

- 4-bit carry look-ahead adder with registered outputs; computes a + b + c0 and presents a 4-bit sum and a carry-out.
- Carries are computed in parallel from generate/propagate terms, with no ripple chain.
- Also exports group propagate/generate so several instances can be cascaded under a higher-level look-ahead unit.
- Leaf arithmetic block used by wider adders and datapath units.

---
 rtl/cla_pkg.sv | 10 +
 rtl/cla_4b_core.sv | 47 ++++
 rtl/cla_4b.sv | 71 +++++++
 tb/tb_cla_4b.sv | 100 ++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the 4-bit carry look-ahead adder.
//   CLA_WIDTH  : operand width supported by the adder (4)
//   cla_word_t : one 4-bit operand or sum word
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  typedef logic [3:0] cla_word_t;

endpackage : cla_pkg

// File: rtl/cla_4b_core.sv
// Combinational core of the 4-bit carry look-ahead adder.
// Ports:
//   a, b     : in  4-bit unsigned operands
//   c0       : in  carry-in
//   sum_next : out (a + b + c0) mod 16
//   c4       : out carry-out (2^4 bit of a + b + c0)
//   grp_p    : out group propagate p3&p2&p1&p0
//   grp_g    : out group generate, carry produced independent of c0
module cla_4b_core
  import cla_pkg::*;
(
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      c0,
  output cla_word_t sum_next,
  output logic      c4,
  output logic      grp_p,
  output logic      grp_g
);

  cla_word_t  g;
  cla_word_t  p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is written out in sum-of-products form directly from g, p
  // and c0, so no carry depends on another carry (no ripple path).
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  assign sum_next = p ^ c[3:0];
  assign c4       = c[4];

  // Group terms let a higher-level look-ahead unit cascade several blocks.
  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule : cla_4b_core

// File: rtl/cla_4b.sv
// 4-bit carry look-ahead adder with registered outputs (1-cycle latency).
// Ports:
//   clk   : in  clock, rising edge
//   rst   : in  synchronous active-high reset, clears all outputs
//   a, b  : in  4-bit unsigned operands
//   c0    : in  carry-in
//   sum   : out registered (a + b + c0) mod 16
//   c_out : out registered carry-out
//   grp_p : out registered group propagate
//   grp_g : out registered group generate
module cla_4b
  import cla_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                c0,
  output logic [NUM_BITS-1:0] sum,
  output logic                c_out,
  output logic                grp_p,
  output logic                grp_g
);

  if (NUM_BITS != CLA_WIDTH) begin : g_bad_width
    $error("cla_4b: NUM_BITS must be 4");
  end

  cla_word_t sum_p0;
  logic      c4_p0;
  logic      grp_p_p0;
  logic      grp_g_p0;

  cla_4b_core u_core (
    .a        (a),
    .b        (b),
    .c0       (c0),
    .sum_next (sum_p0),
    .c4       (c4_p0),
    .grp_p    (grp_p_p0),
    .grp_g    (grp_g_p0)
  );

  // Stage p0 -> p1: output register; reset discards the in-flight result.
  cla_word_t sum_p1;
  logic      c_out_p1;
  logic      grp_p_p1;
  logic      grp_g_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1   <= '0;
      c_out_p1 <= 1'b0;
      grp_p_p1 <= 1'b0;
      grp_g_p1 <= 1'b0;
    end else begin
      sum_p1   <= sum_p0;
      c_out_p1 <= c4_p0;
      grp_p_p1 <= grp_p_p0;
      grp_g_p1 <= grp_g_p0;
    end
  end

  assign sum   = sum_p1;
  assign c_out = c_out_p1;
  assign grp_p = grp_p_p1;
  assign grp_g = grp_g_p1;

endmodule : cla_4b

// File: tb/tb_cla_4b.sv
// Self-checking bench for cla_4b: directed cases, an exhaustive sweep and
// random vectors, all compared against an arithmetic reference model.
module tb_cla_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c0;
  logic [3:0] sum;
  logic       c_out;
  logic       grp_p;
  logic       grp_g;

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  cla_4b #(.NUM_BITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c0    (c0),
    .sum   (sum),
    .c_out (c_out),
    .grp_p (grp_p),
    .grp_g (grp_g)
  );

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    n_checks++;
    if (observed === expected) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Apply one vector, clock it in, then compare the registered outputs with
  // values computed from plain integer arithmetic.
  task automatic step(input string tag, input logic r, input logic [3:0] va,
                      input logic [3:0] vb, input logic vc);
    int total;
    int gen_only;
    logic [4:0] exp_res;
    logic exp_p;
    logic exp_g;
    rst = r; a = va; b = vb; c0 = vc;
    total    = int'(va) + int'(vb) + int'(vc);
    gen_only = int'(va) + int'(vb);
    if (r) begin
      exp_res = 5'd0; exp_p = 1'b0; exp_g = 1'b0;
    end else begin
      exp_res = total[4:0];
      exp_p   = ((va ^ vb) == 4'hF);   // carry-in passes straight through
      exp_g   = (gen_only >= 16);      // carry produced even with c0 = 0
    end
    @(posedge clk);
    #1;
    check({tag, " sum"},   {4'd0, sum},   {4'd0, exp_res[3:0]});
    check({tag, " c_out"}, {7'd0, c_out}, {7'd0, exp_res[4]});
    check({tag, " grp_p"}, {7'd0, grp_p}, {7'd0, exp_p});
    check({tag, " grp_g"}, {7'd0, grp_g}, {7'd0, exp_g});
  endtask

  initial begin
    rst = 1'b1; a = 4'hF; b = 4'hF; c0 = 1'b1;

    step("reset0", 1'b1, 4'b1111, 4'b1111, 1'b1);
    step("reset1", 1'b1, 4'b1111, 4'b1111, 1'b1);

    step("zero",      1'b0, 4'b0000, 4'b0000, 1'b0);
    step("maxcarry",  1'b0, 4'b1111, 4'b0001, 1'b0);
    step("fullprop1", 1'b0, 4'b1010, 4'b0101, 1'b1);
    step("fullprop0", 1'b0, 4'b1010, 4'b0101, 1'b0);
    step("chain",     1'b0, 4'b0111, 4'b0001, 1'b0);
    step("allones",   1'b0, 4'b1111, 4'b1111, 1'b1);

    step("midrst",    1'b1, 4'b0011, 4'b0100, 1'b1);
    step("postrst",   1'b0, 4'b0011, 4'b0100, 1'b1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step("exh", 1'b0, v[8:5], v[4:1], v[0]);
    end

    for (int i = 0; i < 200; i++) begin
      logic [8:0] v;
      logic       r;
      v = 9'($urandom);
      r = (($urandom % 16) == 0);
      step("rand", r, v[8:5], v[4:1], v[0]);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_cla_4b
